// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps decoded MIDI note on/off onto VOICES voices with
// retrigger/idle/release/steal priority. Optional sustain pedal under `SUSTAIN_PEDAL_EN`.
package MIDI;
    typedef enum logic [3:0] {
        NOTE_OFF         = 4'h8,
        NOTE_ON          = 4'h9,
        POLY_PRESSURE    = 4'hA,
        CONTROL_CHANGE   = 4'hB,
        PROGRAM_CHANGE   = 4'hC,
        CHANNEL_PRESSURE = 4'hD,
        PITCH_BEND       = 4'hE,
        SYSTEM           = 4'hF
    } message_type_t;

    typedef struct packed {
        message_type_t message_type;
        logic [6:0]    data_byte1;
        logic [6:0]    data_byte2;
    } message_t;
endpackage

module voice_allocator #(
    parameter int VOICES = 8
) (
    input  logic                   clock_50_000_000,
    input  logic                   reset,
    input  MIDI::message_t         message,
    input  logic                   message_valid,
    input  logic [VOICES-1:0]      voice_done,
    output logic [VOICES-1:0]      voice_gate,
    output logic [VOICES-1:0]      voice_trigger,
    output logic [VOICES-1:0][6:0] voice_note,
    output logic [VOICES-1:0][6:0] voice_velocity,
    output logic [VOICES-1:0]      voice_busy,
    output logic [VOICES-1:0][1:0] voice_state_dbg_o
);
    localparam int W = $clog2(VOICES);

    typedef enum logic [1:0] {V_IDLE = 2'd0, V_HELD = 2'd1, V_RELEASING = 2'd2} vstate_e;

    vstate_e           state_q [VOICES];
    vstate_e           state_d [VOICES];
    logic [6:0]        note_q  [VOICES];
    logic [6:0]        note_d  [VOICES];
    logic [6:0]        vel_q   [VOICES];
    logic [6:0]        vel_d   [VOICES];
    logic [W-1:0]      rank_q  [VOICES];
    logic [W-1:0]      rank_d  [VOICES];
    logic [VOICES-1:0] trig_q, trig_d;
`ifdef SUSTAIN_PEDAL_EN
    logic [VOICES-1:0] sus_q, sus_d;
    logic              pedal_q, pedal_d;
    logic              is_cc64;
`endif

    logic         is_on, is_off;
    logic         hit_ret, hit_idle, hit_rel, hit_held;
    logic [W-1:0] idx_ret, idx_idle, idx_rel, idx_held, tgt;
    logic [W-1:0] age_rel, age_held;

    assign is_on  = message_valid && message.message_type == MIDI::NOTE_ON
                    && message.data_byte2 != 7'd0;
    assign is_off = message_valid && (message.message_type == MIDI::NOTE_OFF
                    || (message.message_type == MIDI::NOTE_ON && message.data_byte2 == 7'd0));
`ifdef SUSTAIN_PEDAL_EN
    assign is_cc64 = message_valid && message.message_type == MIDI::CONTROL_CHANGE
                     && message.data_byte1 == 7'd64;
`endif

    always_comb begin
        trig_d   = '0;
        hit_ret  = 1'b0;
        hit_idle = 1'b0;
        hit_rel  = 1'b0;
        hit_held = 1'b0;
        idx_ret  = '0;
        idx_idle = '0;
        idx_rel  = '0;
        idx_held = '0;
        age_rel  = '0;
        age_held = '0;
`ifdef SUSTAIN_PEDAL_EN
        sus_d    = sus_q;
        pedal_d  = pedal_q;
`endif
        // Finished releases are retired first so the freed voice is allocatable this cycle.
        for (int i = 0; i < VOICES; i++) begin
            state_d[i] = state_q[i];
            note_d[i]  = note_q[i];
            vel_d[i]   = vel_q[i];
            rank_d[i]  = rank_q[i];
            if (state_q[i] == V_RELEASING && voice_done[i]) state_d[i] = V_IDLE;
        end

        // Candidates per priority class; "oldest" is the highest rank.
        for (int i = 0; i < VOICES; i++) begin
            if (!hit_ret && state_d[i] == V_HELD && note_q[i] == message.data_byte1) begin
                hit_ret = 1'b1;
                idx_ret = W'(i);
            end
            if (!hit_idle && state_d[i] == V_IDLE) begin
                hit_idle = 1'b1;
                idx_idle = W'(i);
            end
            if (state_d[i] == V_RELEASING && (!hit_rel || rank_q[i] > age_rel)) begin
                hit_rel = 1'b1;
                idx_rel = W'(i);
                age_rel = rank_q[i];
            end
            if (state_d[i] == V_HELD && (!hit_held || rank_q[i] > age_held)) begin
                hit_held = 1'b1;
                idx_held = W'(i);
                age_held = rank_q[i];
            end
        end
        tgt = hit_ret ? idx_ret : hit_idle ? idx_idle : hit_rel ? idx_rel : idx_held;

        if (is_on) begin
            state_d[tgt] = V_HELD;
            note_d[tgt]  = message.data_byte1;
            vel_d[tgt]   = message.data_byte2;
            trig_d[tgt]  = 1'b1;
`ifdef SUSTAIN_PEDAL_EN
            sus_d[tgt]   = 1'b0;
`endif
            for (int i = 0; i < VOICES; i++) begin
                if (W'(i) == tgt) rank_d[i] = '0;
                else if (rank_q[i] < rank_q[tgt]) rank_d[i] = rank_q[i] + W'(1);
            end
        end else if (is_off) begin
            for (int i = 0; i < VOICES; i++) begin
                if (state_d[i] == V_HELD && note_q[i] == message.data_byte1) begin
`ifdef SUSTAIN_PEDAL_EN
                    if (pedal_q) sus_d[i] = 1'b1;
                    else state_d[i] = V_RELEASING;
`else
                    state_d[i] = V_RELEASING;
`endif
                end
            end
        end
`ifdef SUSTAIN_PEDAL_EN
        else if (is_cc64) begin
            pedal_d = message.data_byte2[6];
            if (pedal_q && !message.data_byte2[6]) begin
                for (int i = 0; i < VOICES; i++) begin
                    if (sus_q[i]) begin
                        state_d[i] = V_RELEASING;
                        sus_d[i]   = 1'b0;
                    end
                end
            end
        end
`endif
    end

    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < VOICES; i++) begin
                state_q[i] <= V_IDLE;
                note_q[i]  <= '0;
                vel_q[i]   <= '0;
                rank_q[i]  <= W'(i);
            end
            trig_q <= '0;
`ifdef SUSTAIN_PEDAL_EN
            sus_q   <= '0;
            pedal_q <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                state_q[i] <= state_d[i];
                note_q[i]  <= note_d[i];
                vel_q[i]   <= vel_d[i];
                rank_q[i]  <= rank_d[i];
            end
            trig_q <= trig_d;
`ifdef SUSTAIN_PEDAL_EN
            sus_q   <= sus_d;
            pedal_q <= pedal_d;
`endif
        end
    end

    // All outputs decode registered state only.
    always_comb begin
        voice_trigger = trig_q;
        for (int i = 0; i < VOICES; i++) begin
            voice_gate[i]        = state_q[i] == V_HELD;
            voice_busy[i]        = state_q[i] != V_IDLE;
            voice_note[i]        = note_q[i];
            voice_velocity[i]    = vel_q[i];
            voice_state_dbg_o[i] = state_q[i];
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator (VOICES=4): directed scenarios plus random traffic against a
// timestamp-based reference model feeding an expected-output queue.
module tb_voice_allocator;
    localparam int V       = 4;
    localparam int VEL_LO  = 0;
    localparam int NOTE_LO = 7 * V;
    localparam int BUSY_LO = 14 * V;
    localparam int TRIG_LO = 15 * V;
    localparam int GATE_LO = 16 * V;
    localparam int ST_LO   = 17 * V;
    localparam int EW      = 19 * V;

    logic              clk = 1'b0;
    logic              rst;
    MIDI::message_t    msg;
    logic              msg_valid;
    logic [V-1:0]      done;
    logic [V-1:0]      voice_gate, voice_trigger, voice_busy;
    logic [V-1:0][6:0] voice_note, voice_velocity;
    logic [V-1:0][1:0] voice_state;

    voice_allocator #(.VOICES(V)) dut (
        .clock_50_000_000 (clk),
        .reset            (rst),
        .message          (msg),
        .message_valid    (msg_valid),
        .voice_done       (done),
        .voice_gate       (voice_gate),
        .voice_trigger    (voice_trigger),
        .voice_note       (voice_note),
        .voice_velocity   (voice_velocity),
        .voice_busy       (voice_busy),
        .voice_state_dbg_o(voice_state)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    // Reference model: state 0 idle, 1 held, 2 releasing; age by allocation timestamp.
    int       m_state[V];
    int       m_note[V];
    int       m_vel[V];
    int       m_stamp[V];
    bit       m_sus[V];
    bit       m_pedal;
    int       m_clock;
    logic [V-1:0] m_trig;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < V; i++) begin
            m_state[i] = 0;
            m_note[i]  = 0;
            m_vel[i]   = 0;
            m_stamp[i] = 0;
            m_sus[i]   = 1'b0;
        end
        m_pedal = 1'b0;
        m_clock = 0;
        m_trig  = '0;
    endtask

    task automatic model_step(input logic [3:0] typ, input int b1, input int b2,
                              input logic valid, input logic [V-1:0] dn);
        int t;
        bit on, off;
        m_trig = '0;
        for (int i = 0; i < V; i++)
            if (m_state[i] == 2 && dn[i]) m_state[i] = 0;
        on  = valid && typ == 4'h9 && b2 != 0;
        off = valid && (typ == 4'h8 || (typ == 4'h9 && b2 == 0));
        if (on) begin
            t = -1;
            for (int i = 0; i < V; i++)
                if (t < 0 && m_state[i] == 1 && m_note[i] == b1) t = i;
            for (int i = 0; i < V; i++)
                if (t < 0 && m_state[i] == 0) t = i;
            for (int s = 2; s >= 1; s--)
                if (t < 0)
                    for (int i = 0; i < V; i++)
                        if (m_state[i] == s && (t < 0 || m_stamp[i] < m_stamp[t])) t = i;
            m_clock++;
            m_state[t] = 1;
            m_note[t]  = b1;
            m_vel[t]   = b2;
            m_stamp[t] = m_clock;
            m_sus[t]   = 1'b0;
            m_trig[t]  = 1'b1;
        end else if (off) begin
            for (int i = 0; i < V; i++)
                if (m_state[i] == 1 && m_note[i] == b1) begin
`ifdef SUSTAIN_PEDAL_EN
                    if (m_pedal) m_sus[i] = 1'b1;
                    else m_state[i] = 2;
`else
                    m_state[i] = 2;
`endif
                end
        end
`ifdef SUSTAIN_PEDAL_EN
        else if (valid && typ == 4'hB && b1 == 64) begin
            if (m_pedal && b2 < 64)
                for (int i = 0; i < V; i++)
                    if (m_sus[i]) begin
                        m_state[i] = 2;
                        m_sus[i]   = 1'b0;
                    end
            m_pedal = b2 >= 64;
        end
`endif
    endtask

    function automatic logic [EW-1:0] model_pack();
        logic [EW-1:0] e;
        e = '0;
        for (int i = 0; i < V; i++) begin
            e[VEL_LO + 7*i +: 7]  = 7'(m_vel[i]);
            e[NOTE_LO + 7*i +: 7] = 7'(m_note[i]);
            e[BUSY_LO + i]        = m_state[i] != 0;
            e[TRIG_LO + i]        = m_trig[i];
            e[GATE_LO + i]        = m_state[i] == 1;
            e[ST_LO + 2*i +: 2]   = 2'(m_state[i]);
        end
        return e;
    endfunction

    task automatic compare_outputs(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check_val({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, ".gate"},  32'(voice_gate),     32'(e[GATE_LO +: V]));
            check_val({tag, ".trig"},  32'(voice_trigger),  32'(e[TRIG_LO +: V]));
            check_val({tag, ".busy"},  32'(voice_busy),     32'(e[BUSY_LO +: V]));
            check_val({tag, ".note"},  32'(voice_note),     32'(e[NOTE_LO +: 7*V]));
            check_val({tag, ".vel"},   32'(voice_velocity), 32'(e[VEL_LO +: 7*V]));
            check_val({tag, ".state"}, 32'(voice_state),    32'(e[ST_LO +: 2*V]));
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".gate"}, 32'(voice_gate),     32'd0);
        check_val({tag, ".trig"}, 32'(voice_trigger),  32'd0);
        check_val({tag, ".busy"}, 32'(voice_busy),     32'd0);
        check_val({tag, ".note"}, 32'(voice_note),     32'd0);
        check_val({tag, ".vel"},  32'(voice_velocity), 32'd0);
    endtask

    task automatic step(input logic [3:0] typ, input int b1, input int b2,
                        input logic valid, input logic [V-1:0] dn, input string tag);
        @(negedge clk);
        msg.message_type = MIDI::message_type_t'(typ);
        msg.data_byte1   = 7'(b1);
        msg.data_byte2   = 7'(b2);
        msg_valid        = valid;
        done             = dn;
        model_step(typ, b1, b2, valid, dn);
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic note_on(input int n, input int v);
        step(4'h9, n, v, 1'b1, '0, "note_on");
    endtask

    task automatic note_off(input int n);
        step(4'h8, n, 0, 1'b1, '0, "note_off");
    endtask

    task automatic idle(input logic [V-1:0] dn);
        step(4'h0, 0, 0, 1'b0, dn, "idle");
    endtask

    // A NOTE_ON is presented during reset and must be dropped.
    task automatic do_reset();
        @(negedge clk);
        rst              = 1'b1;
        msg.message_type = MIDI::NOTE_ON;
        msg.data_byte1   = 7'd50;
        msg.data_byte2   = 7'd50;
        msg_valid        = 1'b1;
        done             = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst       = 1'b0;
        msg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] others[4];
        int         kind, n, v;
        others = '{4'hA, 4'hC, 4'hD, 4'hE};
        rst       = 1'b0;
        msg       = '0;
        msg_valid = 1'b0;
        done      = '0;
        model_reset();
        do_reset();

        // First note lands on voice 0 with a single-cycle trigger.
        note_on(60, 100);
        check_val("first_gate0", 32'(voice_gate[0]), 32'd1);
        check_val("first_note0", 32'(voice_note[0]), 32'd60);
        check_val("first_vel0",  32'(voice_velocity[0]), 32'd100);
        check_val("first_trig",  32'(voice_trigger), 32'b0001);
        idle('0);
        check_val("first_trig_once", 32'(voice_trigger), 32'd0);

        // Velocity-0 note-on releases; voice_done then frees the voice.
        step(4'h9, 60, 0, 1'b1, '0, "vel0_off");
        check_val("vel0_gate0", 32'(voice_gate[0]), 32'd0);
        check_val("vel0_busy0", 32'(voice_busy[0]), 32'd1);
        idle(4'b0001);
        check_val("done_busy0", 32'(voice_busy[0]), 32'd0);

        // Fill all voices, then steal the oldest.
        note_on(60, 10);
        note_on(62, 20);
        note_on(64, 30);
        note_on(65, 40);
        note_on(67, 50);
        check_val("steal_note0", 32'(voice_note[0]), 32'd67);
        check_val("steal_gate",  32'(voice_gate), 32'b1111);
        check_val("steal_trig",  32'(voice_trigger), 32'b0001);

        // Releasing voice freed in the same cycle as a new note takes it.
        note_off(62);
        step(4'h9, 70, 90, 1'b1, 4'b0010, "done_and_on");
        check_val("freed_note1", 32'(voice_note[1]), 32'd70);
        check_val("freed_trig",  32'(voice_trigger), 32'b0010);

        step(4'hE, 12, 34, 1'b1, '0, "pitch_bend");
        note_off(99);
        note_off(67);
        idle(4'b0001);
        // Retrigger of a held note wins over an idle voice.
        note_on(64, 50);
        check_val("retrig_trig", 32'(voice_trigger), 32'b0100);
        check_val("retrig_vel2", 32'(voice_velocity[2]), 32'd50);
        idle(4'b1111);

        // Oldest releasing voice is chosen, not the lowest index.
        note_on(50, 11);
        note_off(65);
        note_off(70);
        note_on(51, 12);
        check_val("oldest_rel_trig", 32'(voice_trigger), 32'b1000);
        note_off(51);
        note_off(64);
        note_off(50);
        idle(4'b1111);

        // Controller 64 behaviour.
        step(4'hB, 64, 127, 1'b1, '0, "cc64_on");
        note_on(60, 80);
        note_off(60);
`ifdef SUSTAIN_PEDAL_EN
        check_val("sustain_gate0", 32'(voice_gate[0]), 32'd1);
`else
        check_val("no_sustain_gate0", 32'(voice_gate[0]), 32'd0);
`endif
        step(4'hB, 64, 0, 1'b1, '0, "cc64_off");
        check_val("pedal_up_gate0", 32'(voice_gate[0]), 32'd0);
        idle(4'b0001);

        for (int k = 0; k < 300; k++) begin
            kind = $urandom_range(0, 9);
            n    = $urandom_range(60, 66);
            v    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
            if (kind <= 3)      step(4'h9, n, v, 1'b1, 4'($urandom_range(0, 15)), "rnd_on");
            else if (kind <= 5) step(4'h8, n, v, 1'b1, 4'($urandom_range(0, 15)), "rnd_off");
            else if (kind == 6) step(4'hB, 64, $urandom_range(0, 127), 1'b1,
                                     4'($urandom_range(0, 15)), "rnd_cc");
            else if (kind == 7) step(others[$urandom_range(0, 3)], n, v, 1'b1,
                                     4'($urandom_range(0, 15)), "rnd_other");
            else                step(4'h0, n, v, 1'b0, 4'($urandom_range(0, 15)), "rnd_idle");
        end

        // Asynchronous reset with three held voices.
        do_reset();
        note_on(60, 1);
        note_on(62, 2);
        note_on(64, 3);
        @(negedge clk);
        msg_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        note_on(72, 9);
        check_val("post_reset_note0", 32'(voice_note[0]), 32'd72);
        check_val("post_reset_trig",  32'(voice_trigger), 32'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter VOICES, default 8, number of polyphonic voices (2..16).
REQ-002 SHALL have port clock_50_000_000 input 1: sole clock, all state on rising edge.
REQ-003 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-004 SHALL have port message input MIDI::message_t: decoded MIDI message (message_type, data_byte1, data_byte2).
REQ-005 SHALL have port message_valid input 1: message is valid this cycle; every valid message is accepted, with no backpressure.
REQ-006 SHALL have port voice_done input VOICES: per-voice level from the envelope, high when the release phase has finished.
REQ-007 SHALL have port voice_gate output VOICES: per-voice gate, high while the note is held.
REQ-008 SHALL have port voice_trigger output VOICES: per-voice one-cycle pulse on (re)allocation.
REQ-009 SHALL have port voice_note output VOICES x 7: MIDI note number per voice.
REQ-010 SHALL have port voice_velocity output VOICES x 7: note-on velocity per voice.
REQ-011 SHALL have port voice_busy output VOICES: voice is in HELD or RELEASING.

Function
REQ-012 SHALL keep a per-voice state: IDLE, HELD or RELEASING.
REQ-013 SHALL define voice transitions as follows:
- IDLE->HELD on allocation.
- HELD->RELEASING on a matching note-off.
- RELEASING->IDLE when voice_done=1.
- RELEASING->HELD on allocation.
REQ-014 SHALL treat a NOTE_ON with velocity 0 as a NOTE_OFF.
REQ-015 SHALL register a NOTE_ON accepted in cycle N so that voice_note, voice_velocity and voice_gate change at edge N+1, with voice_trigger high for exactly cycle N+1.
REQ-016 SHALL choose the NOTE_ON target in this order:
- (a) a HELD voice with the same note (retrigger);
- (b) the lowest-index IDLE voice;
- (c) the oldest RELEASING voice;
- (d) the oldest HELD voice (steal).
REQ-017 SHALL keep age as a per-voice rank 0..VOICES-1: the allocated voice gets rank 0, every voice with a lower previous rank increments by one, and ranks are always a permutation.
REQ-018 SHALL move every HELD voice whose voice_note matches a NOTE_OFF to RELEASING (gate low at N+1); a NOTE_OFF matching no voice SHALL have no effect.
REQ-019 SHALL ignore all other message types and leave the outputs unchanged.
REQ-020 SHALL apply voice_done before allocation in the same cycle, so a voice freed that cycle counts as IDLE.
REQ-021 SHALL ignore voice_done for voices that are not RELEASING.
REQ-022 SHALL deliver a stolen voice's trigger as a pulse with gate held high, with no gate-low cycle.
REQ-023 SHALL contain no combinational path from message to any output.

Reset
REQ-024 SHALL, while reset=1, force all voices to IDLE and voice_gate, voice_trigger and voice_busy to 0.
REQ-025 SHALL, while reset=1, force voice_note and voice_velocity to 0 and rank[i]=i.
REQ-026 SHALL discard any message presented in a cycle in which reset is asserted.
REQ-027 SHALL resume normal operation on the first rising edge after reset deasserts.

Configuration
REQ-028 SHALL, when SUSTAIN_PEDAL_EN is defined, track a pedal flag set by CONTROL_CHANGE controller 64 with value>=64 and cleared by value<64.
REQ-029 SHALL, with the pedal set, mark matching HELD voices "sustained" on NOTE_OFF and keep their gate high.
REQ-030 SHALL move all sustained voices to RELEASING on pedal release, gate low at N+1.
REQ-031 SHALL clear a voice's sustained mark when the voice is retriggered.
REQ-032 SHALL, when SUSTAIN_PEDAL_EN is not defined, ignore controller 64 and add no pedal logic.

Verification
REQ-033 SHALL cover (VOICES=4) reset then NOTE_ON 60/100 -> voice 0 gate=1, note=60, vel=100, trigger=1 for one cycle at N+1.
REQ-034 SHALL cover NOTE_ON 60,62,64,65 then NOTE_ON 67 -> voice 0 (oldest HELD) stolen, note=67, gate stays 1, trigger pulse.
REQ-035 SHALL cover NOTE_ON 60 then NOTE_ON 60 vel=0 -> voice 0 RELEASING with gate=0; then voice_done[0]=1 -> busy[0]=0 next cycle.
REQ-036 SHALL cover voice 1 RELEASING with voice_done[1]=1 in the same cycle as NOTE_ON 70 while voices 0,2,3 are HELD -> voice 1 gets 70.
REQ-037 SHALL cover, with SUSTAIN_PEDAL_EN, CC64=127, NOTE_ON 60, NOTE_OFF 60 -> gate stays 1; then CC64=0 -> gate=0 next cycle.
REQ-038 SHALL cover reset asserted asynchronously mid-sequence with 3 HELD voices -> all outputs 0 immediately, and the next NOTE_ON goes to voice 0.
